volume_control: RTL and testbench
=================================

# volume_control

Upstream control stage for the audio path. Conditions the raw volume-up/volume-down push-buttons and the mute switch, maintains a saturating 5-level volume register, and drives the 3-bit `volume` input of the note generator plus the 5-LED volume bar. All logic is on the crystal clock, with no derived clocks.

## Interface
Parameters:
- `DEB_DIV`, 100000: clock cycles per debounce sample tick (1 ms at 100 MHz).
- `DEB_LEN`, 8: consecutive equal samples required to accept a button level.
- `HOLD_CYC`, 50000000: cycles a debounced button must stay high before auto-repeat starts.
- `REPEAT_CYC`, 15000000: cycles between auto-repeat steps after `HOLD_CYC`.
- `VOL_INIT`, 3'd2: volume level loaded at reset (0..4).

Ports:
- `clk`  in  1  crystal clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_up`  in  1  raw volume-up button, asynchronous and bouncy.
- `btn_down`  in  1  raw volume-down button, asynchronous and bouncy.
- `sw_mute`  in  1  raw mute switch, asynchronous.
- `volume`  out  3  level 0..4 to the note generator; never exceeds 3'd4.
- `mute`  out  1  synchronized mute level.
- `led_vol`  out  5  thermometer bar.
- `vol_changed`  out  1  one-cycle pulse when `volume` changes value.

## Operation
- **Synchronizers:** each raw input passes through two flops before any use.
- **Tick counter:** free-running, 0..DEB_DIV-1. `tick` is high for one cycle when the count equals DEB_DIV-1.
- **Debounce (per button):** on `tick`, shift the synchronized level into a DEB_LEN-bit register.
  - All ones: debounced level becomes 1.
  - All zeros: debounced level becomes 0.
  - Otherwise: debounced level holds.
- **Step generation (per button):**
  - A rising edge of the debounced level produces one step pulse.
  - While the debounced level stays high, a hold counter counts clk cycles. A step fires when it reaches HOLD_CYC, then every REPEAT_CYC cycles after that.
  - The hold counter clears when the debounced level goes low.
- **Conflict:** when both debounced levels are high, no steps are produced and both hold counters stay cleared. Steps on the same cycle from both buttons cancel.
- **Volume register:**
  - An up step increments, saturating at 4. A down step decrements, saturating at 0.
  - A step at a limit produces no change and no `vol_changed`.
- **Mute:**
  - `mute` is the synchronized `sw_mute`.
  - While `mute` is 1, steps are discarded, `volume` holds its value, and `led_vol` = 5'b0.
  - Unmuting restores the bar for the held volume.
- **LED bar:** `led_vol` = (1 << (volume+1)) - 1 when unmuted, so level 0 gives 5'b00001 and level 4 gives 5'b11111.

## Timing
- **Reset values:**
  - `volume` = VOL_INIT, `mute` = 0, `vol_changed` = 0.
  - `led_vol` = thermometer of VOL_INIT.
  - All sync, shift, tick and hold registers = 0.
- **Reset mid-hold:** a reset that arrives during a hold or a bounce discards all pending state. No step may fire in the cycle after `rst` deasserts.
- **Press latency:** from a stable raw press to the step pulse, 2 sync cycles plus DEB_LEN ticks (up to DEB_LEN×DEB_DIV cycles), plus 1 cycle for the edge register.
- **Step to output:** `volume` and `vol_changed` update on the clk edge after the step pulse. `led_vol` updates in that same cycle, driven combinationally from registered state.
- **Release:** a release is recognised after DEB_LEN consecutive zero ticks. Glitches shorter than DEB_LEN ticks never produce a step.
- **Mute latency:** 2 cycles from `sw_mute` to `mute` and LED blanking. A step arriving on the same cycle `mute` rises is discarded.
- **Width rule:** hold and tick counters are sized $clog2 of their parameter and saturate, never wrap. The hold counter restarts at 0 after each repeat step.

## Structure
- **Shared package `audio_pkg`:**
  - `VOL_LEVELS` = 5, `VOL_MAX` = 3'd4, `VOL_W` = 3.
  - The thermometer-decode function, which other blocks reuse.
- **Sub-module `button_conditioner`:** synchronizer, debounce and edge/auto-repeat step generator, parameterised by DEB_LEN, HOLD_CYC and REPEAT_CYC. It takes the shared `tick` as an input and is instantiated once per button.
- **Top:** contains the tick counter, mute synchronizer, conflict logic, volume register and LED decode.

## Test plan
All scenarios use DEB_DIV=4, DEB_LEN=4, HOLD_CYC=64, REPEAT_CYC=16, VOL_INIT=2.
- **Reset:** hold `rst` 3 cycles → `volume`=2, `led_vol`=5'b00111, `vol_changed`=0, `mute`=0.
- **Bounce:** toggle `btn_up` every 3 cycles for 40 cycles, then hold high → exactly one step, `volume`=3 within 2+16+1 cycles of the stable edge, one `vol_changed` pulse.
- **Saturation:** 5 clean `btn_down` presses from level 2 → `volume` reaches 0 after two presses and stays there, `led_vol`=5'b00001, exactly 2 `vol_changed` pulses.
- **Auto-repeat:** hold `btn_up` 200 cycles after debounce from level 0 → steps at the edge, at +64, then every 16 cycles; `volume` stops at 4.
- **Mute:** set `sw_mute`, press `btn_up` → `led_vol`=0 and `volume` unchanged; clear `sw_mute` → `led_vol` shows the held level.
- **Conflict and reset mid-hold:** both buttons held → `volume` unchanged. Assert `rst` during a 50-cycle hold → `volume`=2 and no step in the following 70 cycles while held.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared constants and helpers for the audio control path.
// The thermometer decode lives here so other display blocks can reuse it.
package audio_pkg;

    localparam int VOL_LEVELS = 5;
    localparam int VOL_W = 3;
    localparam logic [VOL_W-1:0] VOL_MAX = 3'd4;

    // Level n lights the lowest n+1 segments; levels beyond the top saturate the bar.
    function automatic logic [VOL_LEVELS-1:0] vol_to_bar(input logic [VOL_W-1:0] level);
        logic [VOL_LEVELS-1:0] bar;
        bar = '0;
        for (int i = 0; i < VOL_LEVELS; i++) begin
            bar[i] = (i <= int'(level));
        end
        return bar;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// Turns one raw push-button into a debounced level and single-cycle step pulses,
// with auto-repeat while the button is held.
module button_conditioner
    import audio_pkg::*;
#(
    parameter int DEB_LEN    = 8,
    parameter int HOLD_CYC   = 50000000,
    parameter int REPEAT_CYC = 15000000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic raw,
    input  logic inhibit,
    output logic level,
    output logic step
);

    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int REP_W  = (REPEAT_CYC > 1) ? $clog2(REPEAT_CYC) : 1;
    localparam int CNT_W  = (HOLD_W > REP_W) ? HOLD_W : REP_W;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);

    logic             sync_a;
    logic             sync_b;
    logic [DEB_LEN-1:0] shift;
    logic [DEB_LEN-1:0] shift_next;
    logic             deb;
    logic             deb_d;
    logic             armed;
    logic             repeating;
    logic [CNT_W-1:0] cnt;
    logic             step_q;
    logic             active;
    logic             edge_fire;
    logic             hold_fire;

    // A button held through reset must first be seen released before it may step.
    always_comb begin
        shift_next = {shift[DEB_LEN-2:0], sync_b};
        active     = deb && deb_d && armed && !inhibit;
        edge_fire  = deb && !deb_d && armed && !inhibit;
        hold_fire  = active && (cnt == (repeating ? REP_LAST : HOLD_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            shift     <= '0;
            deb       <= 1'b0;
            deb_d     <= 1'b0;
            armed     <= 1'b0;
            repeating <= 1'b0;
            cnt       <= '0;
            step_q    <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            if (tick) begin
                shift <= shift_next;
                if (&shift_next) begin
                    deb <= 1'b1;
                end else if (~|shift_next) begin
                    deb   <= 1'b0;
                    armed <= 1'b1;
                end
            end
            deb_d  <= deb;
            step_q <= edge_fire || hold_fire;
            if (!active) begin
                cnt       <= '0;
                repeating <= 1'b0;
            end else if (hold_fire) begin
                cnt       <= '0;
                repeating <= 1'b1;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign level = deb;
    assign step  = step_q;

endmodule

// File: rtl/volume_control.sv
// Button/mute conditioning and saturating volume register feeding the note
// generator and the LED volume bar.
module volume_control
    import audio_pkg::*;
#(
    parameter int         DEB_DIV    = 100000,
    parameter int         DEB_LEN    = 8,
    parameter int         HOLD_CYC   = 50000000,
    parameter int         REPEAT_CYC = 15000000,
    parameter logic [2:0] VOL_INIT   = 3'd2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       sw_mute,
    output logic [2:0] volume,
    output logic       mute,
    output logic [4:0] led_vol,
    output logic       vol_changed
);

    localparam int TICK_W = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DEB_DIV - 1);

    logic [TICK_W-1:0] tick_cnt;
    logic              tick;
    logic              mute_a;
    logic              mute_q;
    logic              up_level;
    logic              down_level;
    logic              up_step;
    logic              down_step;
    logic              conflict;
    logic              go_up;
    logic              go_down;
    logic [VOL_W-1:0]  vol_q;
    logic              changed_q;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
            mute_a   <= 1'b0;
            mute_q   <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);
            mute_a   <= sw_mute;
            mute_q   <= mute_a;
        end
    end

    assign conflict = up_level && down_level;

    button_conditioner #(
        .DEB_LEN    (DEB_LEN),
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) up_cond (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .raw     (btn_up),
        .inhibit (conflict),
        .level   (up_level),
        .step    (up_step)
    );

    button_conditioner #(
        .DEB_LEN    (DEB_LEN),
        .HOLD_CYC   (HOLD_CYC),
        .REPEAT_CYC (REPEAT_CYC)
    ) down_cond (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .raw     (btn_down),
        .inhibit (conflict),
        .level   (down_level),
        .step    (down_step)
    );

    // Coincident up/down steps cancel, and everything is dropped while muted.
    assign go_up   = up_step && !down_step && !mute_q;
    assign go_down = down_step && !up_step && !mute_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            vol_q     <= VOL_INIT;
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (go_up && (vol_q < VOL_MAX)) begin
                vol_q     <= vol_q + VOL_W'(1);
                changed_q <= 1'b1;
            end else if (go_down && (vol_q != '0)) begin
                vol_q     <= vol_q - VOL_W'(1);
                changed_q <= 1'b1;
            end
        end
    end

    assign volume      = vol_q;
    assign vol_changed = changed_q;
    assign mute        = mute_q;
    assign led_vol     = mute_q ? 5'b00000 : vol_to_bar(vol_q);

endmodule

// File: tb/tb_volume_control.sv
// Directed bench for volume_control: expected volume changes are queued when
// stimulus is applied and compared as each vol_changed pulse arrives.
module tb_volume_control;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       sw_mute;
    logic [2:0] volume;
    logic       mute;
    logic [4:0] led_vol;
    logic       vol_changed;

    int         checks;
    int         failures;
    int         pulses;
    logic [2:0] exp_q[$];
    longint     times[$];

    volume_control #(
        .DEB_DIV    (4),
        .DEB_LEN    (4),
        .HOLD_CYC   (64),
        .REPEAT_CYC (16),
        .VOL_INIT   (3'd2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .sw_mute     (sw_mute),
        .volume      (volume),
        .mute        (mute),
        .led_vol     (led_vol),
        .vol_changed (vol_changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every change pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && vol_changed) begin
            pulses++;
            times.push_back($time);
            check_output("change_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                check_output("change_value", volume, exp_q.pop_front());
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        wait_cycles(n);
        rst = 1'b0;
    endtask

    task automatic apply_stimulus(input logic up, input logic down, input int high, input int settle);
        btn_up   = up;
        btn_down = down;
        wait_cycles(high);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        wait_cycles(settle);
    endtask

    task automatic wait_pulse(input int base, input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (pulses > base) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   base;
        int   base2;
        logic seen;
        checks   = 0;
        failures = 0;
        pulses   = 0;
        rst      = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        sw_mute  = 1'b0;

        // Reset state
        wait_cycles(3);
        check_output("reset_volume", volume, 2);
        check_output("reset_led", led_vol, 5'b00111);
        check_output("reset_changed", vol_changed, 0);
        check_output("reset_mute", mute, 0);
        rst = 1'b0;
        wait_cycles(10);

        // Bounce then stable press: a single step to 3
        exp_q.push_back(3'd3);
        base = pulses;
        for (int i = 0; i < 40; i++) begin
            btn_up = ((i / 3) % 2 == 0);
            @(negedge clk);
        end
        btn_up = 1'b1;
        wait_pulse(base, 21, seen);
        check_output("bounce_latency", seen, 1);
        wait_cycles(10);
        btn_up = 1'b0;
        wait_cycles(40);
        check_output("bounce_pulses", pulses - base, 1);
        check_output("bounce_volume", volume, 3);
        check_output("bounce_queue", exp_q.size(), 0);

        // Saturation at the bottom
        apply_reset(3);
        wait_cycles(10);
        check_output("sat_start", volume, 2);
        exp_q.push_back(3'd1);
        exp_q.push_back(3'd0);
        base = pulses;
        for (int i = 0; i < 5; i++) apply_stimulus(1'b0, 1'b1, 30, 40);
        check_output("sat_pulses", pulses - base, 2);
        check_output("sat_volume", volume, 0);
        check_output("sat_led", led_vol, 5'b00001);
        check_output("sat_queue", exp_q.size(), 0);

        // Auto-repeat from 0 up to the top
        times.delete();
        for (int v = 1; v <= 4; v++) exp_q.push_back(3'(v));
        base = pulses;
        apply_stimulus(1'b1, 1'b0, 225, 40);
        check_output("rep_pulses", pulses - base, 4);
        check_output("rep_volume", volume, 4);
        check_output("rep_led", led_vol, 5'b11111);
        check_output("rep_queue", exp_q.size(), 0);
        check_output("rep_count", times.size(), 4);
        if (times.size() >= 4) begin
            check_output("rep_hold_gap", 32'((times[1] - times[0]) / 10), 64);
            check_output("rep_gap1", 32'((times[2] - times[1]) / 10), 16);
            check_output("rep_gap2", 32'((times[3] - times[2]) / 10), 16);
        end

        // Mute blanks the bar and discards steps
        sw_mute = 1'b1;
        wait_cycles(3);
        check_output("mute_on", mute, 1);
        check_output("mute_led", led_vol, 0);
        base = pulses;
        apply_stimulus(1'b0, 1'b1, 30, 40);
        check_output("mute_volume", volume, 4);
        check_output("mute_led_held", led_vol, 0);
        check_output("mute_pulses", pulses - base, 0);
        sw_mute = 1'b0;
        wait_cycles(3);
        check_output("unmute", mute, 0);
        check_output("unmute_led", led_vol, 5'b11111);

        // Both buttons together do nothing
        base = pulses;
        apply_stimulus(1'b1, 1'b1, 100, 40);
        check_output("conflict_volume", volume, 4);
        check_output("conflict_pulses", pulses - base, 0);

        // Reset mid-hold, button kept down afterwards
        exp_q.push_back(3'd3);
        base = pulses;
        btn_down = 1'b1;
        wait_cycles(70);
        check_output("hold_edge_step", volume, 3);
        apply_reset(2);
        check_output("rst_hold_volume", volume, 2);
        check_output("rst_hold_changed", vol_changed, 0);
        base2 = pulses;
        wait_cycles(70);
        check_output("rst_hold_pulses", pulses - base2, 0);
        check_output("rst_hold_volume_after", volume, 2);
        check_output("rst_hold_total", pulses - base, 1);
        btn_down = 1'b0;
        wait_cycles(40);
        check_output("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
